// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline run/halt sequencer.
// The datapath and decoder take HALT_OPCODE from here as well.
package pipe_ctrl_pkg;

  localparam logic [6:0] HALT_OPCODE = 7'b1111111;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    HALTED  = 2'd2,
    RESUME  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_OPCODE = 2'd1,
    CAUSE_EXT    = 2'd2,
    CAUSE_STEP   = 2'd3
  } cause_e;

endpackage

// File: rtl/pipe_halt_ctrl.sv
// Run/halt sequencer: detects halt requests, drains EX/MEM/WB, freezes the pipe
// and redirects fetch to the captured PC on resume or single-step.
module pipe_halt_ctrl #(
  parameter int unsigned         PC_W         = 9,
  parameter int unsigned         OPCODE_W     = 7,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE  = pipe_ctrl_pkg::HALT_OPCODE,
  parameter int unsigned         DRAIN_CYCLES = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic                id_valid,
  input  logic [PC_W-1:0]     id_pc,
  input  logic [PC_W-1:0]     if_pc,
  input  logic                id_stall,
  input  logic                ex_flush,
  input  logic                ext_halt_req,
  input  logic                resume,
  input  logic                step,
  output logic                pc_en,
  output logic                pc_load,
  output logic [PC_W-1:0]     resume_pc,
  output logic                ifid_flush,
  output logic                idex_bubble,
  output logic                pipe_freeze,
  output logic                mem_block,
  output logic                halted,
  output logic [1:0]          halt_cause
);
  import pipe_ctrl_pkg::*;

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(1'b0);
  localparam logic [PC_W-1:0]  PC_STRIDE  = PC_W'(3'd4);

  state_e          state_r;
  logic [CNT_W-1:0] cnt_r;
  logic            step_pending_r;
  logic            issued_once_r;
  logic [PC_W-1:0] resume_pc_r;
  cause_e          cause_r;

  logic            opc_halt_s;
  logic            ext_trig_s;
  logic            step_trig_s;
  logic            trig_s;
  cause_e          trig_cause_s;
  logic [PC_W-1:0] trig_pc_s;

  // Halt trigger detection; a taken branch in EX squashes any trigger because ID is on the wrong path
  always_comb begin
    opc_halt_s   = id_valid && (id_opcode == HALT_OPCODE) && !ex_flush;
    ext_trig_s   = ext_halt_req && !ex_flush;
    step_trig_s  = step_pending_r && issued_once_r && !ex_flush;
    trig_s       = (state_r == RUN) && (opc_halt_s || ext_trig_s || step_trig_s);
    trig_cause_s = CAUSE_NONE;
    trig_pc_s    = id_valid ? id_pc : if_pc;
    if (opc_halt_s) begin
      trig_cause_s = CAUSE_OPCODE;
      trig_pc_s    = id_pc + PC_STRIDE;
    end else if (ext_trig_s) begin
      trig_cause_s = CAUSE_EXT;
    end else begin
      trig_cause_s = CAUSE_STEP;
    end
  end

  // Sequencer state, drain counter, step bookkeeping and captured restart PC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= RUN;
      cnt_r          <= CNT_ZERO;
      step_pending_r <= 1'b0;
      issued_once_r  <= 1'b0;
      resume_pc_r    <= '0;
      cause_r        <= CAUSE_NONE;
    end else begin
      case (state_r)
        RUN: begin
          if (trig_s) begin
            state_r        <= DRAIN;
            cnt_r          <= DRAIN_LOAD;
            resume_pc_r    <= trig_pc_s;
            cause_r        <= trig_cause_s;
            step_pending_r <= 1'b0;
            issued_once_r  <= 1'b0;
          end else if (step_pending_r && id_valid && !id_stall && !ex_flush) begin
            issued_once_r  <= 1'b1;
          end
        end
        DRAIN: begin
          if (cnt_r == CNT_ZERO) begin
            state_r <= HALTED;
          end else begin
            cnt_r   <= cnt_r - CNT_ONE;
          end
        end
        HALTED: begin
          // resume outranks step; a held external request pins the halt
          if (resume && !ext_halt_req) begin
            state_r        <= RESUME;
            step_pending_r <= 1'b0;
          end else if (step && !ext_halt_req) begin
            state_r        <= RESUME;
            step_pending_r <= 1'b1;
          end
        end
        RESUME: begin
          state_r       <= RUN;
          cause_r       <= CAUSE_NONE;
          issued_once_r <= 1'b0;
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

  // Strobe decode from state, plus the combinational trigger cycle in RUN
  always_comb begin
    pc_en       = 1'b0;
    pc_load     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    mem_block   = 1'b0;
    halted      = 1'b0;
    case (state_r)
      RUN: begin
        pc_en       = !trig_s;
        ifid_flush  = trig_s;
        idex_bubble = trig_s;
      end
      DRAIN: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      HALTED: begin
        pipe_freeze = 1'b1;
        mem_block   = 1'b1;
        halted      = 1'b1;
      end
      RESUME: begin
        pc_load     = 1'b1;
        pc_en       = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      default: begin
        pc_en = 1'b0;
      end
    endcase
  end

  assign resume_pc  = resume_pc_r;
  assign halt_cause = cause_r;

endmodule

// File: tb/tb_pipe_halt_ctrl.sv
// Directed self-checking bench for pipe_halt_ctrl.
module tb_pipe_halt_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] id_opcode;
  logic       id_valid;
  logic [8:0] id_pc;
  logic [8:0] if_pc;
  logic       id_stall;
  logic       ex_flush;
  logic       ext_halt_req;
  logic       resume;
  logic       step;
  logic       pc_en;
  logic       pc_load;
  logic [8:0] resume_pc;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       pipe_freeze;
  logic       mem_block;
  logic       halted;
  logic [1:0] halt_cause;

  int passed = 0;
  int total  = 0;

  pipe_halt_ctrl dut (
    .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_valid(id_valid),
    .id_pc(id_pc), .if_pc(if_pc), .id_stall(id_stall), .ex_flush(ex_flush),
    .ext_halt_req(ext_halt_req), .resume(resume), .step(step),
    .pc_en(pc_en), .pc_load(pc_load), .resume_pc(resume_pc),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .pipe_freeze(pipe_freeze), .mem_block(mem_block), .halted(halted),
    .halt_cause(halt_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; id_opcode = 7'h13; id_valid = 1'b0; id_pc = 9'h000; if_pc = 9'h000;
    id_stall = 1'b0; ex_flush = 1'b0; ext_halt_req = 1'b0; resume = 1'b0; step = 1'b0;
    #3;
    chk("rst_pc_en", pc_en, 1);
    chk("rst_flush", ifid_flush, 0);
    chk("rst_halted", halted, 0);
    chk("rst_resume_pc", resume_pc, 0);
    chk("rst_cause", halt_cause, 0);
    tick(); tick();
    reset = 1'b0;

    // HALT in ID on the wrong path: no trigger
    id_valid = 1'b1; id_opcode = 7'h7f; id_pc = 9'h010; ex_flush = 1'b1;
    #1;
    chk("flush_no_trig_pc_en", pc_en, 1);
    chk("flush_no_trig_flush", ifid_flush, 0);
    tick();
    chk("flush_stays_run", halted, 0);
    chk("flush_stays_run_pc_en", pc_en, 1);

    // Opcode halt at 0x010
    ex_flush = 1'b0;
    #1;
    chk("opc_trig_pc_en", pc_en, 0);
    chk("opc_trig_flush", ifid_flush, 1);
    chk("opc_trig_bubble", idex_bubble, 1);
    tick();
    id_valid = 1'b0; id_opcode = 7'h13;
    chk("opc_drain1_halted", halted, 0);
    chk("opc_drain1_pc_en", pc_en, 0);
    tick();
    tick();
    chk("opc_drain3_halted", halted, 0);
    tick();
    chk("opc_halted", halted, 1);
    chk("opc_mem_block", mem_block, 1);
    chk("opc_freeze", pipe_freeze, 1);
    chk("opc_resume_pc", resume_pc, 9'h014);
    chk("opc_cause", halt_cause, 1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("opc_resume_load", pc_load, 1);
    chk("opc_resume_pc_en", pc_en, 1);
    tick();
    chk("opc_run_load", pc_load, 0);
    chk("opc_run_pc_en", pc_en, 1);
    chk("opc_run_cause", halt_cause, 0);

    // External halt with nothing valid in ID
    ext_halt_req = 1'b1; if_pc = 9'h020;
    #1;
    chk("ext_trig_flush", ifid_flush, 1);
    tick(); tick(); tick(); tick();
    chk("ext_halted", halted, 1);
    chk("ext_resume_pc", resume_pc, 9'h020);
    chk("ext_cause", halt_cause, 2);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("ext_resume_blocked", halted, 1);
    chk("ext_resume_blocked_load", pc_load, 0);
    ext_halt_req = 1'b0;
    tick();
    chk("ext_still_halted", halted, 1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("ext_resume_load", pc_load, 1);
    chk("ext_resume_load_pc", resume_pc, 9'h020);
    tick();
    chk("ext_run_pc_en", pc_en, 1);
    chk("ext_run_load", pc_load, 0);

    // Halt again at 0x010 to set up a single-step
    id_valid = 1'b1; id_opcode = 7'h7f; id_pc = 9'h010;
    tick();
    id_valid = 1'b0; id_opcode = 7'h13;
    tick(); tick(); tick();
    chk("step_setup_halted", halted, 1);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_resume_load", pc_load, 1);
    chk("step_resume_pc", resume_pc, 9'h014);
    tick();
    chk("step_run1_no_trig", ifid_flush, 0);
    // Stepped instruction held by a load-use stall for two cycles
    id_valid = 1'b1; id_pc = 9'h014; id_stall = 1'b1;
    #1;
    chk("step_stall1_no_trig", ifid_flush, 0);
    tick();
    chk("step_stall2_no_trig", ifid_flush, 0);
    tick();
    id_stall = 1'b0;
    #1;
    chk("step_issue_no_trig", ifid_flush, 0);
    tick();
    id_pc = 9'h018;
    #1;
    chk("step_retrig_flush", ifid_flush, 1);
    chk("step_retrig_pc_en", pc_en, 0);
    tick();
    id_valid = 1'b0;
    tick(); tick(); tick();
    chk("step_halted", halted, 1);
    chk("step_resume_pc_cap", resume_pc, 9'h018);
    chk("step_cause", halt_cause, 3);

    // Back to RUN, then reset in the middle of a drain
    resume = 1'b1;
    tick();
    resume = 1'b0;
    tick();
    id_valid = 1'b1; id_opcode = 7'h7f; id_pc = 9'h030;
    tick();
    id_valid = 1'b0; id_opcode = 7'h13;
    tick();
    chk("mid_drain_flush", ifid_flush, 1);
    chk("mid_drain_cause", halt_cause, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_pc_en", pc_en, 1);
    chk("async_rst_flush", ifid_flush, 0);
    chk("async_rst_halted", halted, 0);
    chk("async_rst_cause", halt_cause, 0);
    chk("async_rst_resume_pc", resume_pc, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_run", pc_en, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_halt_ctrl.md
Name: pipe_halt_ctrl

Overview:
Central run/halt sequencer for the 5-stage RISC-V pipeline. It detects a HALT opcode in ID or an external halt request, then drains EX/MEM/WB. It freezes the pipeline and data memory, captures the resume PC, and on resume or single-step redirects fetch to that PC. The datapath consumes its stall, flush, bubble, freeze and PC-load strobes, alongside the hazard and branch units.

Parameters:
PC_W, 9, program counter width
OPCODE_W, 7, opcode field width
HALT_OPCODE, 7'b1111111, opcode that requests halt
DRAIN_CYCLES, 3, cycles needed to retire EX, MEM and WB contents

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
id_opcode  in  OPCODE_W  opcode of the IF/ID instruction
id_valid  in  1  IF/ID holds a real (non-flushed) instruction
id_pc  in  PC_W  PC of the IF/ID instruction
if_pc  in  PC_W  current fetch PC
id_stall  in  1  load-use stall from hazard unit
ex_flush  in  1  taken branch in EX (PcSel)
ext_halt_req  in  1  level halt request (debug/testbench)
resume  in  1  one-cycle pulse, leave halt
step  in  1  one-cycle pulse, execute one instruction then re-halt
pc_en  out  1  PC register update enable
pc_load  out  1  force PC <= resume_pc
resume_pc  out  PC_W  captured restart PC
ifid_flush  out  1  clear IF/ID
idex_bubble  out  1  inject NOP control into ID/EX
pipe_freeze  out  1  hold all pipeline registers
mem_block  out  1  gate data-memory read/write
halted  out  1  pipeline fully halted
halt_cause  out  2  0 none, 1 opcode, 2 external, 3 step

Behaviour:
- Reset (async): state RUN, step_pending=0, drain counter 0, resume_pc=0, halt_cause=0. Outputs: pc_en=1, all other strobes 0.
- Outputs are a Moore decode of state, except the RUN halt-trigger cycle, which is combinational.
- RUN: pc_en=1, strobes 0.
  - opc_halt = id_valid && id_opcode==HALT_OPCODE && !ex_flush. The flush wins because the HALT is on the wrong path.
  - ext_trig = ext_halt_req && !ex_flush. It is deferred one cycle while a branch flushes.
  - step_trig = step_pending && issued_once && !ex_flush.
  - Priority is opc_halt > ext_trig > step_trig.
- Trigger cycle: pc_en=0, ifid_flush=1, idex_bubble=1.
  - Capture resume_pc: id_pc+4 (mod 2^PC_W) for an opcode halt. Otherwise id_valid ? id_pc : if_pc.
  - The bubbled instruction re-executes after resume. id_stall does not block the trigger.
  - Set halt_cause, load counter with DRAIN_CYCLES-1, go to DRAIN.
- issued_once is a flag set in RUN when step_pending && id_valid && !id_stall && !ex_flush. It is cleared on RESUME.
- DRAIN: pc_en=0, ifid_flush=1, idex_bubble=1; EX/MEM/WB advance normally. The counter decrements each cycle; at 0 go to HALTED. ext_halt_req, resume and step are ignored.
- HALTED: pipe_freeze=1, mem_block=1, halted=1, pc_en=0.
  - resume && !ext_halt_req goes to RESUME with step_pending=0.
  - step && !ext_halt_req goes to RESUME with step_pending=1.
  - resume and step together: resume wins.
  - With ext_halt_req high, state stays HALTED.
- RESUME (1 cycle): pc_load=1, pc_en=1, ifid_flush=1, idex_bubble=1, halt_cause cleared, then RUN.
- resume/step pulses in RUN, DRAIN or RESUME are dropped.
- Reset mid-DRAIN or HALTED returns to RUN immediately, asynchronously.
- Total halt latency from trigger to halted=1 is 1+DRAIN_CYCLES cycles.

Decomposition:
- Package pipe_ctrl_pkg: state enum {RUN, DRAIN, HALTED, RESUME}, halt_cause enum, HALT_OPCODE constant.
- Datapath and decoder import HALT_OPCODE from this package.
- Single module. The drain counter is inline; no sub-module.

Test Plan:
- HALT at id_pc=0x010, id_valid=1 -> trigger cycle pc_en=0, ifid_flush=1. halted=1 exactly 4 cycles later. resume_pc=0x014, halt_cause=1, mem_block=1.
- HALT in ID with ex_flush=1 in the same cycle -> no trigger, state stays RUN, halted stays 0.
- ext_halt_req rises with id_valid=0, if_pc=0x020 -> resume_pc=0x020, halt_cause=2. A resume pulse while ext_halt_req=1 is ignored. After release, resume -> 1 cycle pc_load=1 with 0x020, then pc_en=1.
- From HALTED with resume_pc=0x014, step pulse -> RESUME, then one instruction issues. The next ID instruction at 0x018 triggers a halt with halt_cause=3 and resume_pc=0x018.
- Step issue held by id_stall=1 for 2 cycles -> no re-halt until the instruction issues.
- reset asserted mid-DRAIN (counter=1) -> outputs return to RUN values asynchronously. halted=0, halt_cause=0, resume_pc=0.
